logic_trainer_sequencer: RTL
============================

// Module: logic_trainer_sequencer
// PURPOSE
//  Self-test / auto-demo controller for the trainer kit's 2-input gate selector.
//  - Drives the selector's a, b and sel inputs.
//  - Walks all 7 gates (AND..XNOR), each through all 4 input combos, holding each step DWELL cycles so the LEDs are readable.
//  - Samples the selector output y into a per-gate truth table and checks it against the golden table.
//  - Reports pass/fail and the first failing gate. Sits between the kit's push-buttons and the gate selector.
// PARAMETERS
//  DWELL   4  cycles each {gate,combo} is held before sampling; legal range 1..2**CNT_W-1
//  CNT_W   8  dwell timer width
// PORTS
//  clk        in   1  single system clock
//  rst        in   1  synchronous, active-high reset
//  start      in   1  level; sampled only in IDLE/DONE; launches a run
//  abort      in   1  level; returns to IDLE next cycle from any state
//  step       in   1  manual advance (used only with SEQ_MANUAL_STEP_EN)
//  y_i        in   1  selector output being tested
//  a_o        out  1  to selector a (= combo[1])
//  b_o        out  1  to selector b (= combo[0])
//  sel_o      out  3  to selector sel (= current gate index 0..6)
//  busy       out  1  high in SETTLE/SAMPLE/CHECK
//  done       out  1  high while in DONE
//  pass       out  1  valid when done: 1 = all 7 gates matched
//  fail_gate  out  3  index of first mismatching gate; 3'b111 if none
//  tt_o       out  4  truth table captured so far for current gate; bit i = y at {a,b}=i
// BEHAVIOUR
//  Reset (rst=1 at a clk edge) clears all outputs/registers to 0, except fail_gate=3'b111; state -> IDLE.
//  FSM: IDLE, SETTLE, SAMPLE, CHECK, DONE; all outputs registered.
//  - IDLE: a_o=b_o=0, sel_o=0, busy=0.
//    - start=1 -> SETTLE; gate=0, combo=0, timer=DWELL-1, tt=0, fail cleared, fail_gate=7.
//  - SETTLE: drive sel_o=gate, {a_o,b_o}=combo; decrement timer; at timer==0 -> SAMPLE (exactly DWELL cycles in SETTLE).
//  - SAMPLE (1 cycle): tt[combo] <= y_i.
//    - combo==3 -> CHECK.
//    - else combo++, timer reload -> SETTLE.
//  - CHECK (1 cycle): compare tt with EXP[gate].
//    - On mismatch with fail==0: fail<=1, fail_gate<=gate (first failure sticks).
//    - gate==6 -> DONE; else gate++, combo=0, tt=0, timer reload -> SETTLE.
//  - DONE: done=1, busy=0, pass=~fail; sel_o/a_o/b_o hold last values.
//    - start=1 relaunches a run (same as from IDLE).
//  Golden EXP (bit3..0 = combos 11,10,01,00):
//    AND=1000, OR=1110, NOT(a)=0011, NAND=0111, NOR=0001, XOR=0110, XNOR=1001.
//  Timing: after the edge that samples start, done rises after exactly 7*(4*(DWELL+1)+1) edges (147 for DWELL=4).
//  Priority at each edge: rst > abort > start > step/timer.
//  - abort in any state -> IDLE next cycle; outputs as IDLE; pass=0, done=0.
//  - start while busy is ignored (no restart mid-run).
//  - start and abort both high -> abort wins; start must be re-presented.
//  - rst mid-run behaves as reset (all results lost).
//  - combo and gate never wrap: gate 6 -> DONE, never 7. sel_o is never 3'b111 while busy.
//  - Timer reload value is DWELL-1, truncated to CNT_W. DWELL=1 gives 1-cycle SETTLE.
// CONFIGURATION
//  SEQ_MANUAL_STEP_EN defined:
//  - SETTLE ignores the timer and exits to SAMPLE on the first rising edge of step.
//  - Edge = step registered high while previous sample low; edge detect lives in the block.
//  - A step edge outside SETTLE is discarded. Latency formula does not apply.
//  Not defined: step is unused (tie-off permitted); dwell timer governs SETTLE.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0, fail_gate=7, state IDLE; hold rst and pulse start -> no activity.
//  2. DWELL=4, ideal gate model, start 1 cycle -> sel_o steps 0..6, {a,b} 00,01,10,11 per gate;
//     done=1 exactly 147 edges later; pass=1, fail_gate=7.
//  3. Model forces NAND combo 11 to 1 -> done with pass=0, fail_gate=3; injecting a second fault at XOR leaves fail_gate=3.
//  4. abort at cycle 40 of a run -> next cycle busy=0, sel_o=0, a_o=b_o=0, done=0; later start runs a full clean pass.
//  5. start held high throughout a run -> no restart while busy; on DONE, start relaunches immediately (done drops next cycle).
//  6. SEQ_MANUAL_STEP_EN, 28 step pulses 3 cycles apart -> one SAMPLE per pulse; done after 28th pulse plus CHECK; pass=1.

Source files
------------

// File: rtl/logic_trainer_sequencer.sv
// logic_trainer_sequencer
//   Self-test / auto-demo controller for the trainer kit's 2-input gate
//   selector. Walks gates 0..6 (AND, OR, NOT(a), NAND, NOR, XOR, XNOR),
//   applies each of the four {a,b} combos for DWELL cycles, samples the
//   selector output into a truth table, and compares each table with the
//   golden one. Reports pass and the first failing gate.
//
// Parameters
//   DWELL  cycles each {gate,combo} is held before sampling (1..2**CNT_W-1)
//   CNT_W  dwell timer width
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   start      launch a run (sampled only when idle or done)
//   abort      return to idle on the next edge from any state
//   step       manual advance (only with SEQ_MANUAL_STEP_EN)
//   y_i        selector output under test
//   a_o, b_o   selector inputs (combo[1], combo[0])
//   sel_o      selector gate index 0..6
//   busy       high while a run is in progress
//   done       high once the run has finished
//   pass       valid with done: all seven gates matched
//   fail_gate  first mismatching gate, 3'b111 if none
//   tt_o       truth table captured so far for the current gate
//
// Build option
//   SEQ_MANUAL_STEP_EN: SETTLE exits on a rising edge of step instead of
//   on dwell-timer expiry.

module logic_trainer_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       step,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic [2:0] sel_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_gate,
    output logic [3:0] tt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t           state;
    logic [2:0]       gate;
    logic [1:0]       combo;
    logic [CNT_W-1:0] timer;
    logic             fail;
    logic             settle_exit;
    logic             mismatch;

    // Golden truth tables, bit i = expected y at {a,b} = i.
    function automatic logic [3:0] exp_tt(input logic [2:0] g);
        case (g)
            3'd0:    exp_tt = 4'b1000;  // AND
            3'd1:    exp_tt = 4'b1110;  // OR
            3'd2:    exp_tt = 4'b0011;  // NOT(a)
            3'd3:    exp_tt = 4'b0111;  // NAND
            3'd4:    exp_tt = 4'b0001;  // NOR
            3'd5:    exp_tt = 4'b0110;  // XOR
            3'd6:    exp_tt = 4'b1001;  // XNOR
            default: exp_tt = 4'b0000;
        endcase
    endfunction

`ifdef SEQ_MANUAL_STEP_EN
    logic step_r;
    logic step_rr;

    // step is registered first, then edge-detected against its previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r  <= 1'b0;
            step_rr <= 1'b0;
        end else begin
            step_r  <= step;
            step_rr <= step_r;
        end
    end

    assign settle_exit = step_r & ~step_rr;
`else
    logic unused_step;
    assign unused_step = step;
    assign settle_exit = (timer == '0);
`endif

    assign mismatch = (tt_o != exp_tt(gate));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gate      <= '0;
            combo     <= '0;
            timer     <= '0;
            fail      <= 1'b0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            sel_o     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_gate <= 3'b111;
            tt_o      <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            gate  <= '0;
            combo <= '0;
            a_o   <= 1'b0;
            b_o   <= 1'b0;
            sel_o <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            tt_o  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_SETTLE;
                        gate      <= '0;
                        combo     <= '0;
                        timer     <= RELOAD;
                        fail      <= 1'b0;
                        a_o       <= 1'b0;
                        b_o       <= 1'b0;
                        sel_o     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_gate <= 3'b111;
                        tt_o      <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_exit) state <= S_SAMPLE;
                    else             timer <= timer - 1'b1;
                end
                S_SAMPLE: begin
                    tt_o[combo] <= y_i;
                    if (combo == 2'd3) begin
                        state <= S_CHECK;
                    end else begin
                        state        <= S_SETTLE;
                        combo        <= combo + 2'd1;
                        {a_o, b_o}   <= combo + 2'd1;
                        timer        <= RELOAD;
                    end
                end
                S_CHECK: begin
                    if (mismatch && !fail) begin
                        fail      <= 1'b1;
                        fail_gate <= gate;
                    end
                    if (gate == 3'd6) begin
                        // pass uses this cycle's compare as fail is not yet updated
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= ~(fail | mismatch);
                    end else begin
                        state <= S_SETTLE;
                        gate  <= gate + 3'd1;
                        sel_o <= gate + 3'd1;
                        combo <= '0;
                        a_o   <= 1'b0;
                        b_o   <= 1'b0;
                        tt_o  <= '0;
                        timer <= RELOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
